// File: rtl/sr_pkg.sv
// Shared definitions for the line-buffer sequencer: state encoding, pixel width
// and the modular bank-index rotate used to map bank outputs onto column fields.
package sr_pkg;

   localparam int PIXEL_WIDTH = 24;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic int bank_rot(input int a, input int b, input int nbank);
      return (a + b) % nbank;
   endfunction

endpackage

// File: rtl/line_buffer_ctrl_cnt.sv
// Column / row / write-bank position counters for the line-buffer sequencer.
// Everything advances only on an accepted pixel; the column wrap drives the rest.
module line_buffer_ctrl_cnt #(
   parameter int LINE_WIDTH   = 960,
   parameter int FRAME_HEIGHT = 540,
   parameter int NBANK        = 4,
   parameter int CW           = 10,
   parameter int RW           = 10,
   parameter int BW           = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adv,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic [BW-1:0] wbank,
   output logic          col_last,
   output logic          row_last
);

   assign col_last = (col == CW'(LINE_WIDTH - 1));
   assign row_last = (row == RW'(FRAME_HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col   <= '0;
         row   <= '0;
         wbank <= '0;
      end else if (adv) begin
         if (col_last) begin
            col   <= '0;
            row   <= row_last ? '0 : row + 1'b1;
            // Bank rotation keeps going across frames; FILL never relies on contents.
            wbank <= (wbank == BW'(NBANK - 1)) ? '0 : wbank + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Rotating line-buffer sequencer: writes the current line bank, reads the same
// column from the other banks and emits one NBANK-pixel vertical column per pixel.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_FILL | priming lines 0..NBANK-2, writes only, no output
//   ST_RUN  | write current bank, read all others, one column per accept
module line_buffer_ctrl
   import sr_pkg::*;
#(
   parameter int DATA_WIDTH   = PIXEL_WIDTH,
   parameter int LINE_WIDTH   = 960,
   parameter int FRAME_HEIGHT = 540,
   parameter int NBANK        = 4,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NBANK*DATA_WIDTH-1:0] out_data,
   output logic                        out_eol,
   output logic                        out_eof,
   output logic [NBANK-1:0]            bank_cs,
   output logic [NBANK-1:0]            bank_we,
   output logic [NBANK-1:0]            bank_re,
   output logic [ADDR_WIDTH-1:0]       bank_waddr,
   output logic [ADDR_WIDTH-1:0]       bank_raddr,
   output logic [DATA_WIDTH-1:0]       bank_din,
   input  logic [NBANK*DATA_WIDTH-1:0] bank_dout
);

   localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int BW = $clog2(NBANK);
   localparam logic [RW-1:0] PRIME_ROW = RW'(NBANK - 2);

   logic [0:0]            state;
   logic [0:0]            state_n;
   logic                  acc;
   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [BW-1:0]         wbank;
   logic                  col_last;
   logic                  row_last;
   logic [DATA_WIDTH-1:0] pix_q;
   logic [BW-1:0]         wbank_q;

   assign in_ready = !out_valid || out_ready;
   // rst_n gates acceptance so no bank strobe can fire while held in reset.
   assign acc      = in_valid && in_ready && rst_n;

   line_buffer_ctrl_cnt #(
      .LINE_WIDTH   (LINE_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT),
      .NBANK        (NBANK),
      .CW           (CW),
      .RW           (RW),
      .BW           (BW)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (acc),
      .col      (col),
      .row      (row),
      .wbank    (wbank),
      .col_last (col_last),
      .row_last (row_last)
   );

   always_comb begin
      state_n = state;
      case (state)
         ST_FILL: if (acc && col_last && row == PRIME_ROW) state_n = ST_RUN;
         ST_RUN:  if (acc && col_last && row_last)         state_n = ST_FILL;
         default: state_n = ST_FILL;
      endcase
   end

   always_comb begin
      bank_we = '0;
      bank_re = '0;
      for (int k = 0; k < NBANK; k++) begin
         if (acc && wbank == BW'(k))
            bank_we[k] = 1'b1;
         else if (acc && state == ST_RUN)
            bank_re[k] = 1'b1;
      end
   end

   assign bank_cs    = bank_we | bank_re;
   assign bank_waddr = ADDR_WIDTH'(col);
   assign bank_raddr = ADDR_WIDTH'(col);
   assign bank_din   = in_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_FILL;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
         pix_q     <= '0;
         wbank_q   <= '0;
      end else begin
         state <= state_n;
         if (acc && state == ST_RUN) begin
            out_valid <= 1'b1;
            pix_q     <= in_data;
            wbank_q   <= wbank;
            out_eol   <= col_last;
            out_eof   <= col_last && row_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
         end
      end
   end

   // Oldest line sits in the bank just after the one written with the staged pixel.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < NBANK - 1; i++) begin
         out_data[i*DATA_WIDTH +: DATA_WIDTH] =
            bank_dout[bank_rot(int'(wbank_q), i + 1, NBANK)*DATA_WIDTH +: DATA_WIDTH];
      end
      out_data[(NBANK-1)*DATA_WIDTH +: DATA_WIDTH] = pix_q;
   end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a small behavioural bank model
// (registered read, old data on read-during-write, dout holds when re is low).
module tb_line_buffer_ctrl;

   localparam int DW = 24;
   localparam int LW = 4;
   localparam int FH = 4;
   localparam int NB = 3;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [NB*DW-1:0] out_data;
   logic            out_eol;
   logic            out_eof;
   logic [NB-1:0]   bank_cs;
   logic [NB-1:0]   bank_we;
   logic [NB-1:0]   bank_re;
   logic [AW-1:0]   bank_waddr;
   logic [AW-1:0]   bank_raddr;
   logic [DW-1:0]   bank_din;
   logic [NB*DW-1:0] bank_dout;

   logic [DW-1:0]   mem [NB][LW];
   logic [DW-1:0]   dout_r [NB];

   int vectors = 0;
   int errors  = 0;
   int lines   = 0;

   always #5 clk = ~clk;

   line_buffer_ctrl #(
      .DATA_WIDTH   (DW),
      .LINE_WIDTH   (LW),
      .FRAME_HEIGHT (FH),
      .NBANK        (NB),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_eol    (out_eol),
      .out_eof    (out_eof),
      .bank_cs    (bank_cs),
      .bank_we    (bank_we),
      .bank_re    (bank_re),
      .bank_waddr (bank_waddr),
      .bank_raddr (bank_raddr),
      .bank_din   (bank_din),
      .bank_dout  (bank_dout)
   );

   always @(posedge clk) begin
      for (int k = 0; k < NB; k++) begin
         if (bank_cs[k] && bank_we[k]) mem[k][bank_waddr[1:0]] <= bank_din;
         if (bank_cs[k] && bank_re[k]) dout_r[k] <= mem[k][bank_raddr[1:0]];
      end
   end
   assign bank_dout = {dout_r[2], dout_r[1], dout_r[0]};

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return DW'(r * 16 + c);
   endfunction

   // field 0 = oldest line (row-2), field 2 = newest (row)
   function automatic logic [NB*DW-1:0] colv(input int r, input int c);
      return {pix(r, c), pix(r - 1, c), pix(r - 2, c)};
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One accepted pixel with out_ready high; checks strobes, then the column it produces.
   task automatic px(input int r, input int c);
      logic [NB-1:0] we_e;
      logic [NB-1:0] re_e;
      we_e = 3'b001 << (lines % NB);
      re_e = (r >= NB - 1) ? (~we_e & 3'b111) : 3'b000;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = pix(r, c);
      out_ready = 1'b1;
      #1;
      chk("in_ready", in_ready, 1);
      chk("bank_we", bank_we, we_e);
      chk("bank_re", bank_re, re_e);
      chk("bank_cs", bank_cs, we_e | re_e);
      chk("bank_addr", {bank_waddr, bank_raddr}, {AW'(c), AW'(c)});
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, (r >= NB - 1));
      if (r >= NB - 1) begin
         chk("out_data", out_data, colv(r, c));
         chk("out_eol", out_eol, (c == LW - 1));
         chk("out_eof", out_eof, (c == LW - 1) && (r == FH - 1));
      end
      if (c == LW - 1) lines++;
   endtask

   task automatic line(input int r);
      for (int c = 0; c < LW; c++) px(r, c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB*DW-1:0] q_d [$];
      logic             q_eol [$];
      logic             q_eof [$];
      int               r;
      int               c;
      int               sent;
      int               got;

      // reset with in_valid high: strobes must stay quiet
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 24'h000055;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cs", bank_cs, 0);
      chk("rst_we", bank_we, 0);
      chk("rst_re", bank_re, 0);
      chk("rst_out_valid", out_valid, 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_eol", out_eol, 0);
      chk("rst_eof", out_eof, 0);
      chk("rst_addr", bank_waddr, 0);

      // frame A: prime, steady with backpressure, rotation
      line(0);
      line(1);
      px(2, 0);
      px(2, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = pix(2, 2);
         out_ready = 1'b0;
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_cs", bank_cs, 0);
         chk("bp_out_valid", out_valid, 1);
         @(posedge clk);
         #1;
         chk("bp_out_data", out_data, colv(2, 1));
      end
      px(2, 2);
      px(2, 3);
      line(3);

      // frame B: back in FILL with rotated banks, then reset mid-line
      line(0);
      line(1);
      px(2, 0);
      px(2, 1);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = pix(2, 2);
      #1;
      chk("midrst_cs", bank_cs, 0);
      @(posedge clk);
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_addr", bank_waddr, 0);
      chk("midrst_eol", out_eol, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      lines    = 0;
      #1;
      chk("midrst_in_ready", in_ready, 1);

      // frame C: fresh prime after reset
      line(0);
      line(1);
      line(2);
      line(3);

      // drain, then two frames of random valid/ready against a column scoreboard
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      r    = 0;
      c    = 0;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 2000 && got < 16; cyc++) begin
         @(negedge clk);
         in_valid  = (sent < 2 * LW * FH) && ($urandom_range(0, 3) != 0);
         in_data   = pix(r, c);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         chk("rnd_in_ready", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            if (q_d.size() == 0) begin
               chk("rnd_spurious_col", out_valid, 0);
            end else begin
               chk("rnd_data", out_data, q_d.pop_front());
               chk("rnd_eol", out_eol, q_eol.pop_front());
               chk("rnd_eof", out_eof, q_eof.pop_front());
               got++;
            end
         end
         if (in_valid && in_ready) begin
            if (r >= NB - 1) begin
               q_d.push_back(colv(r, c));
               q_eol.push_back(c == LW - 1);
               q_eof.push_back((c == LW - 1) && (r == FH - 1));
            end
            sent++;
            if (c == LW - 1) begin
               c = 0;
               r = (r == FH - 1) ? 0 : r + 1;
            end else begin
               c = c + 1;
            end
         end
         @(posedge clk);
      end
      chk("rnd_columns", got, 16);
      chk("rnd_pixels", sent, 2 * LW * FH);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for a rotating line buffer built from NBANK `bram_subbank` instances, each holding one image line. It sits between the AXI-stream pixel input and the upscaling window logic. It writes incoming pixels into the current line bank and reads the same column from all other banks. It emits one vertical column of NBANK pixels per accepted input pixel once NBANK-1 lines have been primed.

## Interface
Parameters:
- `DATA_WIDTH`, 24, pixel width (RGB888)
- `LINE_WIDTH`, 960, pixels per line; bank depth
- `FRAME_HEIGHT`, 540, lines per frame
- `NBANK`, 4, number of line banks (≥2); output column height
- `ADDR_WIDTH`, 32, bank address width (upper bits driven 0)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  input pixel valid
- `in_ready`  out  1  input accepted when `in_valid & in_ready`
- `in_data`  in  DATA_WIDTH  raster-order pixel
- `out_valid`  out  1  column valid
- `out_ready`  in  1  downstream accepts column
- `out_data`  out  NBANK*DATA_WIDTH  field i = pixel of line (row-NBANK+1+i); field NBANK-1 = newest line
- `out_eol`  out  1  column is last of its line
- `out_eof`  out  1  column is last of frame
- `bank_cs`  out  NBANK  per-bank chip select
- `bank_we`  out  NBANK  per-bank write enable (one-hot or zero)
- `bank_re`  out  NBANK  per-bank read enable
- `bank_waddr`, `bank_raddr`  out  ADDR_WIDTH  shared address, both equal to current column
- `bank_din`  out  DATA_WIDTH  equals `in_data`
- `bank_dout`  in  NBANK*DATA_WIDTH  concatenated bank outputs, bank k at [k*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Banks have 1-cycle registered read. Read and write in the same cycle return old data. `dout` holds when `re` is low.
- Accept: `acc = in_valid & in_ready`. `in_ready = !out_valid | out_ready` (combinational, no bubble at full throughput).
- Counters: `col` 0..LINE_WIDTH-1, `row` 0..FRAME_HEIGHT-1, `wbank` 0..NBANK-1. All advance only on `acc`. `col` wraps to 0 at LINE_WIDTH-1, and that same wrap increments `row` and rotates `wbank` (mod NBANK). `row` wraps at FRAME_HEIGHT-1.
- State FILL (row < NBANK-1):
  - `acc` asserts `bank_cs[wbank]` and `bank_we[wbank]` at address `col`.
  - No reads, no output.
  - FILL→RUN on the wrap of line NBANK-2.
- State RUN:
  - `acc` writes `wbank` and asserts `bank_re`/`bank_cs` for every bank ≠ `wbank`, all at `col`.
  - Stage registers capture `in_data`, `wbank`, eol = (col==LINE_WIDTH-1), eof = eol & (row==FRAME_HEIGHT-1).
  - `out_valid` is set next cycle.
  - RUN→FILL on the eof accept, with `row`/`col` at 0. `wbank` continues rotating; FILL makes no assumption about bank contents.
- Output mapping: field i (i<NBANK-1) = `bank_dout` of bank (wbank_q+1+i) mod NBANK; field NBANK-1 = staged pixel.
- `out_valid` clears on `out_ready` unless a new `acc` occurs in the same cycle.
- No top/bottom border padding. The first output row is frame row NBANK-1.

## Timing
- Reset values: `out_valid`=0, `out_eol`=0, `out_eof`=0, staged pixel=0, `col`=`row`=`wbank`=0, state=FILL.
- Bank strobes are all 0 while `rst_n` is low. `in_ready`=1 after reset.
- Latency: accept in cycle t → `out_valid` in t+1. Throughput is 1 column/cycle with `out_ready` held high.
- Stall: while `out_valid & !out_ready`, no accept and no read strobes, so `bank_dout` and `out_data` stay stable.
- Reset mid-line or mid-frame: everything returns to FILL. The partial line is discarded and bank contents are ignored.
- `out_data` is don't-care while `out_valid`=0.

## Structure
- Shared package `sr_pkg`: FILL/RUN state encoding, bank-index rotate helper (`(a+b) % NBANK`), and pixel width constant.
- Natural sub-module: `line_buffer_top` instantiates `line_buffer_ctrl` plus NBANK `bram_subbank` instances. The controller itself contains no memory.

## Test plan
Use LINE_WIDTH=4, FRAME_HEIGHT=4, NBANK=3, pixel = row*16+col.
- Prime: stream rows 0–1 with `out_ready`=1. Required: no `out_valid`; `bank_we` one-hot on bank 0 then bank 1; addresses 0..3.
- Steady: stream row 2. Required: 4 columns, each one cycle after accept; column 0 = {0x00, 0x10, 0x20}; `out_eol` on column 3 only.
- Rotation: stream row 3. Required: writes go to bank 0; column 1 = {0x11, 0x21, 0x31}; `out_eof` on column 3; state returns to FILL.
- Backpressure: during row 2, hold `out_ready`=0 for 3 cycles after column 1. Required: `in_ready`=0, `out_data` stable at {0x01, 0x11, 0x21}, no bank strobes; resumes with no loss or duplication.
- Reset mid-line: assert `rst_n`=0 after row 2 column 1. Required: next cycle `out_valid`=0 and counters 0; a fresh frame is primed correctly, with the first output {0x00, 0x10, 0x20}.
- Random valid/ready: 2 full frames with random `in_valid`/`out_ready`. Scoreboard matches a reference column model, with 2*2*4=16 columns total.
